// File: rtl/prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : prefetch_queue
// Brief    : Instruction prefetch stage. Drives the ROM word index, captures
//            the combinational read word and buffers it as bytes in a
//            circular queue. The decoder pops one byte per handshake, tagged
//            with its linear EIP. A flush empties the queue and restarts
//            fetching at a new byte address.
// Revision : 1.0 - initial release
// ============================================================================
module prefetch_queue #(
    parameter int unsigned QUEUE_BYTES = 16,
    parameter logic [31:0] RESET_EIP   = 32'h0000_0000
) (
    input  logic                           clock,
    input  logic                           reset,
    output logic [31:0]                    read_address,
    input  logic [31:0]                    read_data,
    output logic                           fetch_active,
    input  logic                           flush,
    input  logic [31:0]                    flush_eip,
    output logic                           byte_valid,
    output logic [7:0]                     byte_data,
    output logic [31:0]                    byte_eip,
    input  logic                           byte_ready,
    output logic [$clog2(QUEUE_BYTES):0]   queue_count
);

    localparam int unsigned          c_PTR_W = $clog2(QUEUE_BYTES);
    localparam int unsigned          c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]   c_DEPTH = c_CNT_W'(QUEUE_BYTES);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [31:0]          r_fetch_eip;   // byte address of the next fetch
    logic [31:0]          r_head_eip;    // EIP of the byte at rd_ptr
    logic [7:0]           r_queue [QUEUE_BYTES];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic [2:0]           w_fetch_size;  // 1..4 bytes left in the current word
    logic [c_CNT_W-1:0]   w_free;
    logic [c_CNT_W-1:0]   w_fetch_add;
    logic [c_CNT_W-1:0]   w_pop_sub;
    logic [c_CNT_W-1:0]   w_count_next;
    logic                 w_fetch;
    logic                 w_pop;
    logic [31:0]          w_fetch_eip_next;

    // Per-lane write enable and destination slot for the fetched word.
    logic [3:0]           w_lane_we;
    logic [c_PTR_W-1:0]   w_lane_slot [4];

    assign w_fetch_size = 3'd4 - {1'b0, r_fetch_eip[1:0]};

    // Free space is judged on the registered count only, so byte_ready never
    // reaches fetch_active or read_address combinationally.
    assign w_free  = c_DEPTH - r_count;
    assign w_fetch = reset && !flush
                     && (w_free >= {{(c_CNT_W-3){1'b0}}, w_fetch_size});

    assign w_pop   = byte_valid && byte_ready;

    assign w_fetch_add  = w_fetch ? {{(c_CNT_W-3){1'b0}}, w_fetch_size} : '0;
    assign w_pop_sub    = w_pop ? c_CNT_W'(1) : '0;
    assign w_count_next = r_count + w_fetch_add - w_pop_sub;

    // After a fetch the next access always starts on a word boundary; the
    // 30-bit word index wraps naturally from 32'hFFFF_FFFC to zero.
    assign w_fetch_eip_next = {r_fetch_eip[31:2] + 30'd1, 2'b00};

    // Lane k of read_data is queued only when it lies at or above the fetch
    // offset; lanes are packed contiguously from wr_ptr upward.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_lanes
            assign w_lane_we[gi]   = w_fetch
                                     && ({1'b0, r_fetch_eip[1:0]} <= 3'(gi));
            assign w_lane_slot[gi] = r_wr_ptr + c_PTR_W'(gi)
                                     - c_PTR_W'(r_fetch_eip[1:0]);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign read_address = {2'b00, r_fetch_eip[31:2]};
    assign fetch_active = w_fetch;
    assign byte_valid   = (r_count != '0);
    assign byte_data    = byte_valid ? r_queue[r_rd_ptr] : 8'h00;
    assign byte_eip     = r_head_eip;
    assign queue_count  = r_count;

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------

    // Fetch address tracking: flush redirects, otherwise advance on each fetch.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fetch_eip <= RESET_EIP;
        end else if (flush) begin
            r_fetch_eip <= flush_eip;
        end else if (w_fetch) begin
            r_fetch_eip <= w_fetch_eip_next;
        end
    end

    // Head EIP follows pops; a flush restarts it at the new target.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head_eip <= RESET_EIP;
        end else if (flush) begin
            r_head_eip <= flush_eip;
        end else if (w_pop) begin
            r_head_eip <= r_head_eip + 32'd1;
        end
    end

    // Queue pointers and occupancy; a flush discards any same-cycle activity.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_fetch) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(w_fetch_size);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= w_count_next;
        end
    end

    // Byte storage is not reset; contents are qualified by the count.
    always_ff @(posedge clock) begin
        for (int k = 0; k < 4; k++) begin
            if (w_lane_we[k]) begin
                r_queue[w_lane_slot[k]] <= read_data[8*k +: 8];
            end
        end
    end

endmodule
`default_nettype wire
